// File: rtl/pcs_gray_pkg.sv
// Shared Gray-code constants and conversions for the pcs25g 16-entry elastic buffer pointers.
// Used by both the write-side and read-side pointer controllers.
package pcs_gray_pkg;

  localparam int PTR_DEPTH = 16;

  localparam logic [4:0] G0  = 5'b00000;
  localparam logic [4:0] G1  = 5'b00001;
  localparam logic [4:0] G2  = 5'b00011;
  localparam logic [4:0] G3  = 5'b00010;
  localparam logic [4:0] G4  = 5'b00110;
  localparam logic [4:0] G5  = 5'b00111;
  localparam logic [4:0] G6  = 5'b00101;
  localparam logic [4:0] G7  = 5'b00100;
  localparam logic [4:0] G8  = 5'b01100;
  localparam logic [4:0] G9  = 5'b01101;
  localparam logic [4:0] G10 = 5'b01111;
  localparam logic [4:0] G11 = 5'b01110;
  localparam logic [4:0] G12 = 5'b01010;
  localparam logic [4:0] G13 = 5'b01011;
  localparam logic [4:0] G14 = 5'b01001;
  localparam logic [4:0] G15 = 5'b01000;

  function automatic logic [4:0] bin2gray(input logic [3:0] b);
    return {1'b0, b ^ (b >> 1)};
  endfunction

  // Bit4 is ignored here; it is only meaningful to the protocol checker.
  function automatic logic [3:0] gray2bin(input logic [4:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [4:0] gray_next(input logic [4:0] g);
    return bin2gray(gray2bin(g) + 4'd1);
  endfunction

endpackage

// File: rtl/pcs_gray_sync.sv
// Multi-stage synchronizer for a Gray-coded pointer crossing into the local clock domain.
module pcs_gray_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [SYNC_STAGES-1:0][W-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcs_gray_wptr_ctrl.sv
// Write-side pointer controller: binary write pointer, registered Gray publish, fill level/full flags.
// Optional Gray-protocol checker enabled by defining PCS_GRAY_CHECK_EN.
module pcs_gray_wptr_ctrl
  import pcs_gray_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [4:0] rd_gray,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [4:0] wr_gray,
  output logic [3:0] level,
  output logic       full,
  output logic       almost_full,
  output logic       overflow,
  output logic       gray_err
);

  localparam logic [3:0] AFULL_LVL = 4'(AFULL_THRESH);

  logic [4:0] rd_sync;
  logic [3:0] wbin_q, wbin_d;
  logic [4:0] wr_gray_q, wr_gray_d;
  logic [3:0] rbin_q, rbin_d;
  logic       overflow_q, overflow_d;

  pcs_gray_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (5)
  ) u_rd_sync (
    .clk    (clk),
    .rst    (reset),
    .din_i  (rd_gray),
    .dout_o (rd_sync)
  );

  // Decoded read pointer is registered so flags come purely from flops.
  assign level       = wbin_q - rbin_q;
  assign full        = (level == 4'd15);
  assign almost_full = (level >= AFULL_LVL);
  assign wr_en       = wr_req & ~full;
  assign wr_addr     = wbin_q;
  assign wr_gray     = wr_gray_q;
  assign overflow    = overflow_q;

  always_comb begin
    wbin_d     = wr_en ? wbin_q + 4'd1 : wbin_q;
    wr_gray_d  = bin2gray(wbin_d);
    rbin_d     = gray2bin(rd_sync);
    overflow_d = overflow_q | (wr_req & full);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin_q     <= '0;
      wr_gray_q  <= G0;
      rbin_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wr_gray_q  <= wr_gray_d;
      rbin_q     <= rbin_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PCS_GRAY_CHECK_EN
  logic [4:0] rd_prev_q;
  logic [4:0] wr_prev_q;
  logic       gray_err_q, gray_err_d;
  logic       rd_bad_step;
  logic       wr_bad_step;

  // The read pointer may hold or advance by exactly one Gray step.
  assign rd_bad_step = (rd_sync != rd_prev_q) && (rd_sync != gray_next(rd_prev_q));
  assign wr_bad_step = ($countones(wr_gray_q ^ wr_prev_q) > 1);

  always_comb begin
    gray_err_d = gray_err_q | rd_sync[4] | rd_bad_step | wr_bad_step;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_prev_q  <= G0;
      wr_prev_q  <= G0;
      gray_err_q <= 1'b0;
    end else begin
      rd_prev_q  <= rd_sync;
      wr_prev_q  <= wr_gray_q;
      gray_err_q <= gray_err_d;
    end
  end

  assign gray_err = gray_err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule
